// File: rtl/md_sched.sv
// md_sched: multi-cycle multiply/divide scheduler with a private HI/LO pair.
// The result is computed at the start edge and held in a pending register;
// HI/LO only change when the busy countdown expires, so a stalled mfhi/mflo
// never sees a partially complete operation.
module md_sched #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start_e,
    input  logic [1:0]  op_e,
    input  logic [31:0] src_a_e,
    input  logic [31:0] src_b_e,
    input  logic        wr_hi_e,
    input  logic        wr_lo_e,
    input  logic        md_use_d,
    output logic        busy,
    output logic        stall_md,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic {StIdle, StRun} state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] p_hi_q, p_hi_d, p_lo_q, p_lo_d;
    logic [31:0] hi_q, hi_d, lo_q, lo_d;

    logic        is_signed, a_neg, b_neg, div_zero;
    logic [31:0] mag_a, mag_b, divisor, q_mag, r_mag, quot, rem;
    logic [63:0] mul_a, mul_b, prod;
    logic [63:0] result;

    // Combinational arithmetic on the operands present in the start cycle.
    always_comb begin
        is_signed = ~op_e[0];
        a_neg     = is_signed & src_a_e[31];
        b_neg     = is_signed & src_b_e[31];
        mul_a     = {{32{a_neg}}, src_a_e};
        mul_b     = {{32{b_neg}}, src_b_e};
        prod      = mul_a * mul_b;
        // Divide on magnitudes, then restore signs; this also gives the
        // 0x80000000 / -1 case its wrap-around quotient with zero remainder.
        mag_a     = a_neg ? (~src_a_e + 32'd1) : src_a_e;
        mag_b     = b_neg ? (~src_b_e + 32'd1) : src_b_e;
        divisor   = (mag_b == 32'd0) ? 32'd1 : mag_b;
        q_mag     = mag_a / divisor;
        r_mag     = mag_a % divisor;
        quot      = (a_neg ^ b_neg) ? (~q_mag + 32'd1) : q_mag;
        rem       = a_neg ? (~r_mag + 32'd1) : r_mag;
        div_zero  = (src_b_e == 32'd0);
        if (!op_e[1]) begin
            result = prod;
        end else if (div_zero) begin
            // Completing with the current HI/LO leaves them unchanged.
            result = {hi_q, lo_q};
        end else begin
            result = {rem, quot};
        end
    end

    // Next-state logic: start/mthi/mtlo in idle, countdown and commit in run.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        p_hi_d  = p_hi_q;
        p_lo_d  = p_lo_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        unique case (state_q)
            StIdle: begin
                if (start_e) begin
                    {p_hi_d, p_lo_d} = result;
                    cnt_d   = op_e[1] ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);
                    state_d = StRun;
                end else begin
                    if (wr_hi_e) hi_d = src_a_e;
                    if (wr_lo_e) lo_d = src_a_e;
                end
            end
            StRun: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    hi_d    = p_hi_q;
                    lo_d    = p_lo_q;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State registers; reset discards any pending result.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
            p_hi_q  <= 32'd0;
            p_lo_q  <= 32'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            p_hi_q  <= p_hi_d;
            p_lo_q  <= p_lo_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    // Outputs: registered busy, combinational stall request.
    always_comb begin
        busy     = (state_q == StRun);
        stall_md = md_use_d & (start_e | busy);
        hi       = hi_q;
        lo       = lo_q;
    end

endmodule

// File: tb/tb_md_sched.sv
// tb_md_sched: directed vectors with hand-computed HI/LO and busy/stall timing.
module tb_md_sched;

    logic        clk = 1'b0;
    logic        reset;
    logic        start_e;
    logic [1:0]  op_e;
    logic [31:0] src_a_e, src_b_e;
    logic        wr_hi_e, wr_lo_e, md_use_d;
    logic        busy, stall_md;
    logic [31:0] hi, lo;

    int n_vec = 0;
    int n_bad = 0;

    md_sched #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk      (clk),
        .reset    (reset),
        .start_e  (start_e),
        .op_e     (op_e),
        .src_a_e  (src_a_e),
        .src_b_e  (src_b_e),
        .wr_hi_e  (wr_hi_e),
        .wr_lo_e  (wr_lo_e),
        .md_use_d (md_use_d),
        .busy     (busy),
        .stall_md (stall_md),
        .hi       (hi),
        .lo       (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Called at a negedge; drives the start in the current cycle, then
    // follows the N busy cycles and checks the committed HI/LO.
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int n, input logic use_d, input logic wl, input logic poke,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        logic [31:0] old_hi, old_lo;
        old_hi   = hi;
        old_lo   = lo;
        start_e  = 1'b1;
        op_e     = op;
        src_a_e  = a;
        src_b_e  = b;
        wr_lo_e  = wl;
        md_use_d = use_d;
        #1;
        check("stall_start", {63'd0, stall_md}, {63'd0, use_d});
        check("busy_pre", {63'd0, busy}, 64'd0);
        @(negedge clk);
        start_e = 1'b0;
        wr_lo_e = 1'b0;
        for (int i = 0; i < n; i++) begin
            check("busy_run", {63'd0, busy}, 64'd1);
            check("stall_run", {63'd0, stall_md}, {63'd0, use_d});
            check("hi_hold", {32'd0, hi}, {32'd0, old_hi});
            check("lo_hold", {32'd0, lo}, {32'd0, old_lo});
            if (poke && i == 1) begin
                // Start/mthi/mtlo while running must be ignored.
                start_e = 1'b1;
                wr_hi_e = 1'b1;
                wr_lo_e = 1'b1;
                src_a_e = 32'hAB;
                src_b_e = 32'd3;
            end else begin
                start_e = 1'b0;
                wr_hi_e = 1'b0;
                wr_lo_e = 1'b0;
            end
            @(negedge clk);
        end
        start_e = 1'b0;
        wr_hi_e = 1'b0;
        wr_lo_e = 1'b0;
        check("busy_done", {63'd0, busy}, 64'd0);
        check("stall_done", {63'd0, stall_md}, 64'd0);
        check("hi_result", {32'd0, hi}, {32'd0, exp_hi});
        check("lo_result", {32'd0, lo}, {32'd0, exp_lo});
    endtask

    initial begin
        reset = 1'b1; start_e = 1'b0; op_e = 2'b00; src_a_e = 32'd0; src_b_e = 32'd0;
        wr_hi_e = 1'b0; wr_lo_e = 1'b0; md_use_d = 1'b1;
        #1;
        check("stall_in_reset", {63'd0, stall_md}, 64'd0);
        check("busy_reset", {63'd0, busy}, 64'd0);
        check("hi_reset", {32'd0, hi}, 64'd0);
        check("lo_reset", {32'd0, lo}, 64'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        md_use_d = 1'b0;
        @(negedge clk);

        // mult -3*5 = -15
        run_op(2'b00, 32'hFFFFFFFD, 32'd5, 5, 1'b0, 1'b0, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFF1);
        // multu 0xFFFFFFFF*2, stall held by a D-stage user
        run_op(2'b01, 32'hFFFFFFFF, 32'd2, 5, 1'b1, 1'b0, 1'b0, 32'h00000001, 32'hFFFFFFFE);
        md_use_d = 1'b0;
        // div -7/2 -> q=-3, r=-1
        run_op(2'b10, 32'hFFFFFFF9, 32'd2, 10, 1'b0, 1'b0, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFD);
        // divu 7/2
        run_op(2'b11, 32'd7, 32'd2, 10, 1'b0, 1'b0, 1'b0, 32'd1, 32'd3);
        // div overflow case
        run_op(2'b10, 32'h80000000, 32'hFFFFFFFF, 10, 1'b0, 1'b0, 1'b0, 32'd0, 32'h80000000);

        // mthi in idle takes effect at the next edge, no busy cycles
        wr_hi_e = 1'b1;
        src_a_e = 32'h12345678;
        @(negedge clk);
        wr_hi_e = 1'b0;
        check("mthi_hi", {32'd0, hi}, {32'd0, 32'h12345678});
        check("mthi_busy", {63'd0, busy}, 64'd0);

        // div by zero: full duration, HI/LO unchanged, in-flight mtlo ignored
        run_op(2'b10, 32'd99, 32'd0, 10, 1'b0, 1'b0, 1'b1, 32'h12345678, 32'h80000000);

        // reset during a running mult
        start_e = 1'b1; op_e = 2'b00; src_a_e = 32'd3; src_b_e = 32'd4; md_use_d = 1'b0;
        @(negedge clk);
        start_e = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("busy_before_rst", {63'd0, busy}, 64'd1);
        reset = 1'b1;
        #1;
        check("busy_async_rst", {63'd0, busy}, 64'd0);
        check("hi_async_rst", {32'd0, hi}, 64'd0);
        check("lo_async_rst", {32'd0, lo}, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 8; i++) @(negedge clk);
        check("busy_after_rst", {63'd0, busy}, 64'd0);
        check("hi_no_late", {32'd0, hi}, 64'd0);
        check("lo_no_late", {32'd0, lo}, 64'd0);

        // start wins over mtlo, then a back-to-back start with no dead cycle
        run_op(2'b00, 32'd6, 32'd7, 5, 1'b0, 1'b1, 1'b0, 32'd0, 32'd42);
        run_op(2'b11, 32'd100, 32'd7, 10, 1'b0, 1'b0, 1'b0, 32'd2, 32'd14);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/md_sched.md
# md_sched

Multiply/divide scheduler for the five-stage pipeline. It accepts mult/multu/div/divu from the E stage and runs them as a multi-cycle operation on a private HI/LO pair. It applies mthi/mtlo writes and raises a stall request to the hazard logic while a D-stage HI/LO instruction would observe a busy unit. It sits beside the ALU in E; its HI/LO outputs feed the E-stage result mux for mfhi/mflo.

## Interface
Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (legal range 1..15)
- DIV_CYCLES, 10, busy cycles for div/divu (legal range 1..15)

Ports:
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-high reset
- start_e  in  1  E-stage mult/multu/div/divu valid this cycle
- op_e  in  2  00 mult, 01 multu, 10 div, 11 divu
- src_a_e  in  32  rs operand (E stage, forwarded)
- src_b_e  in  32  rt operand (E stage, forwarded)
- wr_hi_e  in  1  E-stage mthi
- wr_lo_e  in  1  E-stage mtlo
- md_use_d  in  1  D-stage instruction is mult/multu/div/divu/mfhi/mflo/mthi/mtlo
- busy  out  1  operation in progress
- stall_md  out  1  stall request to hazard unit = md_use_d & (start_e | busy)
- hi  out  32  architectural HI
- lo  out  32  architectural LO

## Operation
- States: IDLE (busy=0) and RUN (busy=1); 4-bit down-counter cnt; 64-bit pending result {p_hi, p_lo}.
- Reset values: state IDLE, cnt=0, busy=0, hi=0, lo=0, pending=0.
- IDLE, start_e=1:
  - Compute the result from the src_a_e/src_b_e values present in this cycle; latch it into pending.
  - Load cnt with MULT_CYCLES or DIV_CYCLES according to op_e[1]; go to RUN.
- RUN: each edge, cnt decrements.
  - At the edge where cnt==1: copy pending to hi/lo, go to IDLE.
  - busy is therefore high for exactly N cycles after the start edge.
- Arithmetic:
  - mult: signed 32x32 to 64, {hi,lo}=product.
  - multu: unsigned 32x32 to 64, {hi,lo}=product.
  - div: signed; lo=quotient truncated toward zero, hi=remainder with the sign of the dividend.
  - divu: unsigned; lo=quotient, hi=remainder.
  - Divide by zero (src_b_e==0): the operation still occupies DIV_CYCLES; hi/lo remain unchanged at completion.
  - div 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
- mthi/mtlo in IDLE: hi (or lo) <= src_a_e at the same edge; no busy cycles.
- Precedence in IDLE: start_e wins over wr_hi_e/wr_lo_e; the write is dropped.
- start_e, wr_hi_e or wr_lo_e while RUN: ignored, with no effect on cnt, pending, hi or lo. The hazard unit guarantees this never happens via stall_md.
- hi/lo never show pending values before completion.

## Timing
- stall_md and busy are combinational/registered respectively.
  - stall_md reacts in the same cycle to md_use_d, start_e and busy.
  - busy rises the cycle after the start edge.
- Start at edge T0, N=MULT_CYCLES:
  - busy=1 during cycles T0..T0+N-1.
  - hi/lo update at edge T0+N.
  - busy=0 from T0+N.
  - A stalled mflo in D proceeds in the cycle after T0+N and reads the new value in E.
- Back-to-back: a second start_e presented in the first IDLE cycle is accepted; zero dead cycles.
- Asynchronous reset mid-RUN:
  - Immediately forces busy=0, cnt=0, hi=lo=0.
  - Pending is discarded; no write occurs after reset release.
- stall_md is independent of reset state; with busy=0 and start_e=0 it is 0.

## Test plan
- Reset, then mult with a=0xFFFFFFFD (-3), b=5 -> busy high 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFF1; stall_md=0 when md_use_d=0.
- multu with a=0xFFFFFFFF, b=2 -> hi=0x00000001, lo=0xFFFFFFFE. md_use_d=1 held throughout -> stall_md high from start cycle through cycle T0+4, low at T0+5.
- div with a=0xFFFFFFF9 (-7), b=2 -> after 10 busy cycles lo=0xFFFFFFFD, hi=0xFFFFFFFF. divu with a=7, b=2 -> lo=3, hi=1.
- Write hi=0x12345678 via mthi; then div by 0 -> busy 10 cycles, hi stays 0x12345678. mtlo 0xAB while busy -> ignored, lo unchanged.
- Start mult 3*4, assert reset at cycle T0+2 -> busy=0 and hi=lo=0 immediately; after release, hi=lo=0 with no late write.
- start_e with wr_lo_e in the same IDLE cycle (a=6, b=7, mult) -> lo=42 after 5 cycles; the mtlo is dropped. Next start in the first idle cycle -> accepted; busy shows no gap of more than 0 cycles.
